// File: rtl/am29xx_pkg.sv
// Shared types and constants for the am29xx bus controllers.
package am29xx_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SETUP   = 2'd1,
    DRIVE   = 2'd2,
    RELEASE = 2'd3
  } bus_state_t;

  localparam int TURNAROUND = 1;
  localparam int HOLD_W     = 4;

  // Counter load value for a DRIVE phase lasting 'hold' cycles.
  function automatic logic [HOLD_W-1:0] hold_last(input int hold);
    return HOLD_W'(hold - 1);
  endfunction

endpackage

// File: rtl/am2912_bus_ctrl_if.sv
// Handshake, receive and transceiver-side signals of the am2912 bus controller.
interface am2912_bus_ctrl_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             bus_gnt;
  logic             rx_sample;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic [WIDTH-1:0] i;
  logic             e_;
  logic [WIDTH-1:0] z;
  logic             busy;
  logic             err;

  modport master (
    input  tx_data, tx_valid, bus_gnt, rx_sample, z,
    output tx_ready, rx_data, rx_valid, i, e_, busy, err
  );

  modport slave (
    output tx_data, tx_valid, bus_gnt, rx_sample, z,
    input  tx_ready, rx_data, rx_valid, i, e_, busy, err
  );
endinterface

// File: rtl/am2912_rx_reg.sv
// Receive capture register: stores the transceiver z word on request, pulses valid once.
module am2912_rx_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             sample_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o
);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      data_o  <= '0;
      valid_o <= 1'b0;
    end else begin
      if (sample_i) data_o <= d_i;
      valid_o <= sample_i;
    end
  end

endmodule

// File: rtl/am2912_bus_ctrl.sv
// Transfer controller for an am2912 open-collector bus transceiver.
// Define AM2912_COLLIDE_EN to enable the sticky collision detector on err.
module am2912_bus_ctrl
  import am29xx_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int HOLD  = 2
) (
  input  logic clk,
  input  logic rst_,
  am2912_bus_ctrl_if.master bus
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_SETUP   = SETUP;
  localparam logic [1:0] ST_DRIVE   = DRIVE;
  localparam logic [1:0] ST_RELEASE = RELEASE;
  localparam logic [HOLD_W-1:0] HOLD_LAST = hold_last(HOLD);

  logic [1:0]        state_q, state_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]  i_q, i_d;
  logic              e_q, e_d;
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    i_d     = i_q;
    e_d     = 1'b1;
    ready_d = ready_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.tx_valid) begin
          i_d     = bus.tx_data;
          ready_d = 1'b0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (bus.bus_gnt) begin
          cnt_d   = HOLD_LAST;
          e_d     = 1'b0;
          state_d = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        // Grant is deliberately ignored here: a started transfer always runs to completion.
        if (cnt_q == '0) begin
          i_d     = '0;
          state_d = ST_RELEASE;
        end else begin
          cnt_d = cnt_q - HOLD_W'(1);
          e_d   = 1'b0;
        end
      end
      ST_RELEASE: begin
        ready_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: begin
        ready_d = 1'b1;
        i_d     = '0;
        state_d = ST_IDLE;
      end
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  // e_ comes straight from a flop that resets high, so reset releases the bus at once.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      i_q     <= '0;
      e_q     <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      i_q     <= i_d;
      e_q     <= e_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.i        = i_q;
  assign bus.e_       = e_q;
  assign bus.tx_ready = ready_q;
  assign bus.busy     = busy_q;

  am2912_rx_reg #(
    .WIDTH(WIDTH)
  ) u_rx_reg (
    .clk     (clk),
    .rst_    (rst_),
    .sample_i(bus.rx_sample),
    .d_i     (bus.z),
    .data_o  (bus.rx_data),
    .valid_o (bus.rx_valid)
  );

`ifdef AM2912_COLLIDE_EN
  logic err_q;

  // Checked in the last DRIVE cycle, while e_ is still low: a z bit we are not driving is another driver.
  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      err_q <= 1'b0;
    end else if (state_q == ST_DRIVE && cnt_q == '0 && |(bus.z & ~i_q)) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_am2912_bus_ctrl.sv
// Self-checking bench for am2912_bus_ctrl with an emulated am2912 and open-collector pull-up bus.
module tb_am2912_bus_ctrl;
  import am29xx_pkg::*;

  localparam int WIDTH = 4;
  localparam int HOLD  = 2;
`ifdef AM2912_COLLIDE_EN
  localparam logic EXP_COLLIDE = 1'b1;
`else
  localparam logic EXP_COLLIDE = 1'b0;
`endif

  typedef struct {
    logic       tx_valid;
    logic [3:0] tx_data;
    logic       gnt;
    logic       sample;
    logic [3:0] ext;
    logic       exp_e;
    logic [3:0] exp_i;
    logic       exp_ready;
    logic       exp_busy;
    logic [3:0] exp_rx;
    logic       exp_rxv;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_ = 1'b1;
  logic [3:0] ext_drv = 4'b0000;
  logic [3:0] b_;
  int         n_cmp = 0;
  int         n_err = 0;

  am2912_bus_ctrl_if #(.WIDTH(WIDTH)) bus_if ();

  am2912_bus_ctrl #(
    .WIDTH(WIDTH),
    .HOLD (HOLD)
  ) dut (
    .clk (clk),
    .rst_(rst_),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // am2912 emulation: an enabled driver pulls a bus line low for each i=1; undriven lines float high.
  assign b_       = ~(({WIDTH{~bus_if.e_}} & bus_if.i) | ext_drv);
  assign bus_if.z = ~b_;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive_in(input logic v, input logic [3:0] d, input logic g,
                          input logic s, input logic [3:0] x);
    bus_if.tx_valid  = v;
    bus_if.tx_data   = d;
    bus_if.bus_gnt   = g;
    bus_if.rx_sample = s;
    ext_drv          = x;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vecs[19];
    int         a1, a2;
    logic       e_hist[64];
    logic [3:0] i_hist[64];
    int         n, ds;
    bit         act;
    logic [3:0] mdata, m_rx, zm, own, r_data, r_ext;
    logic       m_rxv, m_err, in_drive, released, r_v, r_g, r_s;

    // Single transfer, grant stall, then receive while idle (HOLD = 2).
    vecs[0]  = '{1'b1, 4'b1010, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};
    vecs[1]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b1010, 1'b0, 1'b1, 4'b0000, 1'b0};
    vecs[2]  = '{1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b1, 4'b0000, 1'b0};
    vecs[3]  = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 4'b1010, 1'b0, 1'b1, 4'b1010, 1'b1};
    vecs[4]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[5]  = '{1'b1, 4'b0110, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b1010, 1'b0};
    vecs[6]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[7]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[8]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[9]  = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[10] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[11] = '{1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 4'b0110, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[12] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[13] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 4'b0110, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[14] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b1, 4'b1010, 1'b0};
    vecs[15] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b1010, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[16] = '{1'b0, 4'b0000, 1'b0, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b1010, 1'b1};
    vecs[17] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1};
    vecs[18] = '{1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0};

    drive_in(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    #1 rst_ = 1'b0;
    #2;
    check("rst_e_",       32'(bus_if.e_),       32'd1);
    check("rst_i",        32'(bus_if.i),        32'd0);
    check("rst_tx_ready", 32'(bus_if.tx_ready), 32'd1);
    check("rst_busy",     32'(bus_if.busy),     32'd0);
    check("rst_rx_data",  32'(bus_if.rx_data),  32'd0);
    check("rst_rx_valid", 32'(bus_if.rx_valid), 32'd0);
    check("rst_err",      32'(bus_if.err),      32'd0);
    @(negedge clk);
    rst_ = 1'b1;

    for (int k = 0; k < 19; k++) begin
      @(negedge clk);
      check($sformatf("vec%0d_e_", k),       32'(bus_if.e_),       32'(vecs[k].exp_e));
      check($sformatf("vec%0d_i", k),        32'(bus_if.i),        32'(vecs[k].exp_i));
      check($sformatf("vec%0d_tx_ready", k), 32'(bus_if.tx_ready), 32'(vecs[k].exp_ready));
      check($sformatf("vec%0d_busy", k),     32'(bus_if.busy),     32'(vecs[k].exp_busy));
      check($sformatf("vec%0d_rx_data", k),  32'(bus_if.rx_data),  32'(vecs[k].exp_rx));
      check($sformatf("vec%0d_rx_valid", k), 32'(bus_if.rx_valid), 32'(vecs[k].exp_rxv));
      check($sformatf("vec%0d_err", k),      32'(bus_if.err),      32'd0);
      drive_in(vecs[k].tx_valid, vecs[k].tx_data, vecs[k].gnt, vecs[k].sample, vecs[k].ext);
    end

    // Collision: we drive 0011 while another am2912 drives 0100.
    @(negedge clk);
    drive_in(1'b1, 4'b0011, 1'b1, 1'b0, 4'b0100);
    @(negedge clk);
    drive_in(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0100);
    @(negedge clk);
    check("col_drive1_e_", 32'(bus_if.e_), 32'd0);
    @(negedge clk);
    check("col_drive2_e_", 32'(bus_if.e_), 32'd0);
    drive_in(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0100);
    @(negedge clk);
    check("col_err",      32'(bus_if.err),      32'(EXP_COLLIDE));
    check("col_rx_data",  32'(bus_if.rx_data),  32'h7);
    check("col_rx_valid", 32'(bus_if.rx_valid), 32'd1);
    drive_in(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    repeat (3) @(negedge clk);
    check("col_err_sticky", 32'(bus_if.err),  32'(EXP_COLLIDE));
    check("col_idle_busy",  32'(bus_if.busy), 32'd0);

    // Back-to-back: tx_valid held high across two words.
    @(negedge clk);
    drive_in(1'b1, 4'b0001, 1'b1, 1'b0, 4'b0000);
    a1 = -1;
    a2 = -1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      e_hist[c] = bus_if.e_;
      i_hist[c] = bus_if.i;
      if (bus_if.tx_ready && bus_if.tx_valid) begin
        if (a1 < 0) a1 = c;
        else if (a2 < 0) a2 = c;
      end
      if (a1 >= 0 && c == a1 + 1) bus_if.tx_data = 4'b1000;
      if (a2 >= 0 && c == a2 + 1) bus_if.tx_valid = 1'b0;
      if (a2 >= 0 && c >= a2 + HOLD + 3) break;
    end
    check("b2b_both_accepts", 32'(a1 >= 0 && a2 >= 0), 32'd1);
    if (a1 >= 0 && a2 >= 0 && a2 + 2 < 40) begin
      check("b2b_gap",          32'(a2 - a1),              32'(HOLD + 2 + TURNAROUND));
      check("b2b_setup1_e_",    32'(e_hist[a1 + 1]),       32'd1);
      check("b2b_drive1_e_",    32'(e_hist[a1 + 2]),       32'd0);
      check("b2b_drive1_i",     32'(i_hist[a1 + 2]),       32'h1);
      check("b2b_release_e_",   32'(e_hist[a1 + HOLD + 2]), 32'd1);
      check("b2b_release_i",    32'(i_hist[a1 + HOLD + 2]), 32'h0);
      check("b2b_setup2_e_",    32'(e_hist[a2 + 1]),       32'd1);
      check("b2b_drive2_e_",    32'(e_hist[a2 + 2]),       32'd0);
      check("b2b_drive2_i",     32'(i_hist[a2 + 2]),       32'h8);
    end
    drive_in(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    repeat (HOLD + 4) @(negedge clk);

    // Reset asserted mid-DRIVE must release the bus without waiting for a clock.
    drive_in(1'b1, 4'b1100, 1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    drive_in(1'b0, 4'b0000, 1'b1, 1'b0, 4'b0000);
    @(negedge clk);
    check("mid_drive_e_", 32'(bus_if.e_), 32'd0);
    drive_in(1'b0, 4'b0000, 1'b1, 1'b1, 4'b0000);
    @(negedge clk);
    check("mid_rx_data", 32'(bus_if.rx_data), 32'hc);
    drive_in(1'b0, 4'b0000, 1'b0, 1'b0, 4'b0000);
    #1 rst_ = 1'b0;
    #1;
    check("mid_rst_e_",       32'(bus_if.e_),       32'd1);
    check("mid_rst_i",        32'(bus_if.i),        32'd0);
    check("mid_rst_tx_ready", 32'(bus_if.tx_ready), 32'd1);
    check("mid_rst_busy",     32'(bus_if.busy),     32'd0);
    check("mid_rst_rx_data",  32'(bus_if.rx_data),  32'd0);
    check("mid_rst_err",      32'(bus_if.err),      32'd0);
    repeat (2) @(negedge clk);
    rst_ = 1'b1;

    // Random traffic against a timestamp model: accept, grant seen, HOLD drive cycles, turnaround.
    act   = 1'b0;
    ds    = -1;
    mdata = 4'b0000;
    m_rx  = 4'b0000;
    m_rxv = 1'b0;
    m_err = 1'b0;
    for (n = 0; n < 600; n++) begin
      @(negedge clk);
      in_drive = act && ds >= 0 && n >= ds && n < ds + HOLD;
      released = act && ds >= 0 && n >= ds + HOLD;
      check("rnd_e_",       32'(bus_if.e_),       32'(!in_drive));
      check("rnd_i",        32'(bus_if.i),        32'((act && !released) ? mdata : 4'b0000));
      check("rnd_tx_ready", 32'(bus_if.tx_ready), 32'(!act));
      check("rnd_busy",     32'(bus_if.busy),     32'(act));
      check("rnd_rx_data",  32'(bus_if.rx_data),  32'(m_rx));
      check("rnd_rx_valid", 32'(bus_if.rx_valid), 32'(m_rxv));
      check("rnd_err",      32'(bus_if.err),      32'(m_err));

      r_v    = 1'($urandom_range(0, 1));
      r_data = 4'($urandom);
      r_g    = ($urandom_range(0, 3) != 0);
      r_s    = ($urandom_range(0, 3) == 0);
      r_ext  = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
      drive_in(r_v, r_data, r_g, r_s, r_ext);

      own = in_drive ? mdata : 4'b0000;
      zm  = own | r_ext;
      m_rxv = r_s;
      if (r_s) m_rx = zm;
`ifdef AM2912_COLLIDE_EN
      if (in_drive && n == ds + HOLD - 1 && |(zm & ~mdata)) m_err = 1'b1;
`endif
      if (!act) begin
        if (r_v) begin
          act   = 1'b1;
          mdata = r_data;
          ds    = -1;
        end
      end else if (ds < 0) begin
        if (r_g) ds = n + 1;
      end else if (n + 1 == ds + HOLD + TURNAROUND) begin
        act = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
